// File: rtl/vga_sync_gen.sv
// VGA timing generator: horizontal/vertical pixel counters with registered
// sync, visible and line/frame strobes aligned to the counter values.
module vga_sync_gen #(
  parameter int WIDTH     = 11,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  output logic [WIDTH-1:0] hcnt,
  output logic [WIDTH-1:0] vcnt,
  output logic             hsync,
  output logic             vsync,
  output logic             visible,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  generate
    if (H_VISIBLE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_VISIBLE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_region
      $error("vga_sync_gen: every porch/sync/visible length must be at least 1");
    end
    if (((H_TOTAL - 1) >> WIDTH) != 0 || ((V_TOTAL - 1) >> WIDTH) != 0) begin : g_bad_width
      $error("vga_sync_gen: WIDTH too small for H_TOTAL-1 or V_TOTAL-1");
    end
  endgenerate

  // Region boundaries as WIDTH-bit unsigned constants.
  localparam logic [WIDTH-1:0] H_LAST     = WIDTH'(H_TOTAL - 1);
  localparam logic [WIDTH-1:0] H_VIS_END  = WIDTH'(H_VISIBLE);
  localparam logic [WIDTH-1:0] H_SYNC_BEG = WIDTH'(H_VISIBLE + H_FP);
  localparam logic [WIDTH-1:0] H_SYNC_END = WIDTH'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [WIDTH-1:0] V_LAST     = WIDTH'(V_TOTAL - 1);
  localparam logic [WIDTH-1:0] V_VIS_END  = WIDTH'(V_VISIBLE);
  localparam logic [WIDTH-1:0] V_SYNC_BEG = WIDTH'(V_VISIBLE + V_FP);
  localparam logic [WIDTH-1:0] V_SYNC_END = WIDTH'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic             h_wrap;
  logic             v_wrap;
  logic [WIDTH-1:0] hcnt_nxt;
  logic [WIDTH-1:0] vcnt_nxt;
  logic             hsync_nxt;
  logic             vsync_nxt;
  logic             visible_nxt;

  // Next counter position and the outputs decoded from it, so the registered
  // outputs line up with the registered counters (zero relative latency).
  always_comb begin
    h_wrap   = (hcnt == H_LAST);
    v_wrap   = (vcnt == V_LAST);
    hcnt_nxt = h_wrap ? '0 : hcnt + WIDTH'(1);
    vcnt_nxt = vcnt;
    if (h_wrap) begin
      vcnt_nxt = v_wrap ? '0 : vcnt + WIDTH'(1);
    end
    hsync_nxt   = (hcnt_nxt >= H_SYNC_BEG && hcnt_nxt <= H_SYNC_END) ? HS_POL : ~HS_POL;
    vsync_nxt   = (vcnt_nxt >= V_SYNC_BEG && vcnt_nxt <= V_SYNC_END) ? VS_POL : ~VS_POL;
    visible_nxt = (hcnt_nxt < H_VIS_END) && (vcnt_nxt < V_VIS_END);
  end

  // Counter/output register; reset parks at the last position of the frame so
  // the first enabled pixel lands on (0,0) and raises frame_start.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt        <= H_LAST;
      vcnt        <= V_LAST;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      visible     <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_en) begin
        hcnt        <= hcnt_nxt;
        vcnt        <= vcnt_nxt;
        hsync       <= hsync_nxt;
        vsync       <= vsync_nxt;
        visible     <= visible_nxt;
        line_start  <= h_wrap;
        frame_start <= h_wrap && v_wrap;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen: three configurations (VGA defaults,
// a tiny 8x6 timing, and tiny horizontal with default vertical timing)
// compared every cycle against a linear pixel-index model.
module tb_vga_sync_gen;

  localparam int DHV = 640, DHF = 16, DHS = 96, DHB = 48;
  localparam int DVV = 480, DVF = 10, DVS = 2,  DVB = 33;
  localparam int SHV = 4,   SHF = 1,  SHS = 2,  SHB = 1;
  localparam int SVV = 3,   SVF = 1,  SVS = 1,  SVB = 1;
  localparam int D_HT = DHV + DHF + DHS + DHB, D_VT = DVV + DVF + DVS + DVB;
  localparam int S_HT = SHV + SHF + SHS + SHB, S_VT = SVV + SVF + SVS + SVB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d = 1'b1, rst_s = 1'b1, rst_t = 1'b1;
  logic pix_d = 1'b0, pix_s = 1'b0, pix_t = 1'b0;
  logic [10:0] hc_d, vc_d, hc_s, vc_s, hc_t, vc_t;
  logic hsy_d, vsy_d, vis_d, ls_d, fs_d;
  logic hsy_s, vsy_s, vis_s, ls_s, fs_s;
  logic hsy_t, vsy_t, vis_t, ls_t, fs_t;

  vga_sync_gen u_def (
    .clk(clk), .rst(rst_d), .pix_en(pix_d), .hcnt(hc_d), .vcnt(vc_d),
    .hsync(hsy_d), .vsync(vsy_d), .visible(vis_d), .line_start(ls_d), .frame_start(fs_d));

  vga_sync_gen #(
    .H_VISIBLE(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_VISIBLE(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_small (
    .clk(clk), .rst(rst_s), .pix_en(pix_s), .hcnt(hc_s), .vcnt(vc_s),
    .hsync(hsy_s), .vsync(vsy_s), .visible(vis_s), .line_start(ls_s), .frame_start(fs_s));

  vga_sync_gen #(
    .H_VISIBLE(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB)
  ) u_tall (
    .clk(clk), .rst(rst_t), .pix_en(pix_t), .hcnt(hc_t), .vcnt(vc_t),
    .hsync(hsy_t), .vsync(vsy_t), .visible(vis_t), .line_start(ls_t), .frame_start(fs_t));

  // Model: each instance is a linear pixel index within the frame.
  int p_d = 0, p_s = 0, p_t = 0;
  bit adv_d = 0, adv_s = 0, adv_t = 0;
  bit arm_d = 0, arm_s = 0, arm_t = 0;

  always @(posedge clk) begin
    if (rst_d) begin p_d <= D_HT * D_VT - 1; adv_d <= 0; arm_d <= 1; end
    else if (pix_d) begin p_d <= (p_d + 1) % (D_HT * D_VT); adv_d <= 1; end
    else adv_d <= 0;
    if (rst_s) begin p_s <= S_HT * S_VT - 1; adv_s <= 0; arm_s <= 1; end
    else if (pix_s) begin p_s <= (p_s + 1) % (S_HT * S_VT); adv_s <= 1; end
    else adv_s <= 0;
    if (rst_t) begin p_t <= S_HT * D_VT - 1; adv_t <= 0; arm_t <= 1; end
    else if (pix_t) begin p_t <= (p_t + 1) % (S_HT * D_VT); adv_t <= 1; end
    else adv_t <= 0;
  end

  int n_cmp = 0, n_bad = 0, cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_inst(input string nm, input int p, input bit adv,
                            input int hv, input int hf, input int hs, input int hb,
                            input int vv, input int vf, input int vs, input int vb,
                            input bit hp, input bit vp,
                            input logic [10:0] hc, input logic [10:0] vc,
                            input logic hsy, input logic vsy, input logic vis,
                            input logic ls, input logic fs);
    int ht, h, v;
    bit e_hs, e_vs;
    ht = hv + hf + hs + hb;
    h  = p % ht;
    v  = p / ht;
    e_hs = (h >= hv + hf && h <= hv + hf + hs - 1) ? hp : !hp;
    e_vs = (v >= vv + vf && v <= vv + vf + vs - 1) ? vp : !vp;
    chk({nm, ".hcnt"}, 32'(hc), h);
    chk({nm, ".vcnt"}, 32'(vc), v);
    chk({nm, ".hsync"}, 32'(hsy), 32'(e_hs));
    chk({nm, ".vsync"}, 32'(vsy), 32'(e_vs));
    chk({nm, ".visible"}, 32'(vis), 32'(h < hv && v < vv));
    chk({nm, ".line_start"}, 32'(ls), 32'(adv && h == 0));
    chk({nm, ".frame_start"}, 32'(fs), 32'(adv && p == 0));
  endtask

  // Advance one cycle and compare every armed instance against the model.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (arm_d) check_inst("def", p_d, adv_d, DHV, DHF, DHS, DHB, DVV, DVF, DVS, DVB, 1'b0, 1'b0,
                          hc_d, vc_d, hsy_d, vsy_d, vis_d, ls_d, fs_d);
    if (arm_s) check_inst("small", p_s, adv_s, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, 1'b1, 1'b1,
                          hc_s, vc_s, hsy_s, vsy_s, vis_s, ls_s, fs_s);
    if (arm_t) check_inst("tall", p_t, adv_t, SHV, SHF, SHS, SHB, DVV, DVF, DVS, DVB, 1'b0, 1'b0,
                          hc_t, vc_t, hsy_t, vsy_t, vis_t, ls_t, fs_t);
  endtask

  initial begin
    int k, last, hs_min, hs_max, vis0, hmax, nfs, vmin, vmax;
    logic [7:0] hsm, vsm;

    step(); step();
    rst_d = 0; rst_s = 0; rst_t = 0;

    // Defaults: first enabled pixel, then three lines of horizontal timing.
    pix_d = 1;
    step();
    chk("def_first_hcnt", 32'(hc_d), 0);
    chk("def_first_vcnt", 32'(vc_d), 0);
    chk("def_first_visible", 32'(vis_d), 1);
    chk("def_first_frame_start", 32'(fs_d), 1);
    chk("def_first_hsync", 32'(hsy_d), 1);
    last = cyc; hs_min = 9999; hs_max = -1; vis0 = -1;
    for (int i = 0; i < 3 * D_HT; i++) begin
      step();
      if (hsy_d == 1'b0) begin
        if (int'(hc_d) < hs_min) hs_min = int'(hc_d);
        if (int'(hc_d) > hs_max) hs_max = int'(hc_d);
      end
      if (vis_d == 1'b0 && vis0 < 0) vis0 = int'(hc_d);
      if (ls_d) begin
        chk("def_line_period", cyc - last, D_HT);
        last = cyc;
      end
    end
    chk("def_hsync_first", hs_min, 656);
    chk("def_hsync_last", hs_max, 751);
    chk("def_visible_end", vis0, 640);

    // Reset mid-line with pix_en high: reset wins, then restart at (0,0).
    k = 0;
    while (hc_d != 11'd300 && k < 1000) begin step(); k++; end
    chk("def_reach_h300", 32'(hc_d), 300);
    rst_d = 1;
    step();
    chk("def_rst_hcnt", 32'(hc_d), 799);
    chk("def_rst_vcnt", 32'(vc_d), 524);
    chk("def_rst_line_start", 32'(ls_d), 0);
    chk("def_rst_frame_start", 32'(fs_d), 0);
    chk("def_rst_hsync", 32'(hsy_d), 1);
    chk("def_rst_vsync", 32'(vsy_d), 1);
    chk("def_rst_visible", 32'(vis_d), 0);
    rst_d = 0;
    step();
    chk("def_restart_hcnt", 32'(hc_d), 0);
    chk("def_restart_vcnt", 32'(vc_d), 0);
    chk("def_restart_frame_start", 32'(fs_d), 1);
    pix_d = 0;

    // Small config: region masks, wrap point and frame period.
    pix_s = 1;
    step();
    chk("small_first_hcnt", 32'(hc_s), 0);
    hsm = '0; vsm = '0; hmax = 0; last = cyc;
    for (int i = 0; i < 100; i++) begin
      step();
      if (hsy_s) hsm[hc_s[2:0]] = 1'b1;
      if (vsy_s) vsm[vc_s[2:0]] = 1'b1;
      if (int'(hc_s) > hmax) hmax = int'(hc_s);
      if (fs_s) begin
        chk("small_frame_period", cyc - last, 48);
        last = cyc;
      end
    end
    chk("small_hsync_mask", 32'(hsm), 32'h60);
    chk("small_vsync_mask", 32'(vsm), 32'h10);
    chk("small_hcnt_max", hmax, 7);

    // pix_en 1,0,0,1 across hcnt 3->4, then a single-clk line_start at wrap.
    k = 0;
    while (hc_s != 11'd3 && k < 20) begin step(); k++; end
    chk("small_reach_h3", 32'(hc_s), 3);
    pix_s = 0;
    step();
    chk("small_hold1_hcnt", 32'(hc_s), 3);
    step();
    chk("small_hold2_hcnt", 32'(hc_s), 3);
    chk("small_hold2_line_start", 32'(ls_s), 0);
    pix_s = 1;
    step();
    chk("small_resume_hcnt", 32'(hc_s), 4);
    k = 0;
    while (hc_s != 11'd7 && k < 20) begin step(); k++; end
    chk("small_reach_h7", 32'(hc_s), 7);
    step();
    chk("small_wrap_line_start", 32'(ls_s), 1);
    step();
    chk("small_after_wrap_line_start", 32'(ls_s), 0);
    pix_s = 0;

    // Default vertical timing with a short line: vsync window and frame period.
    pix_t = 1;
    step();
    chk("tall_first_frame_start", 32'(fs_t), 1);
    last = cyc; nfs = 0; vmin = 9999; vmax = -1;
    for (int i = 0; i < S_HT * D_VT + 100; i++) begin
      step();
      if (vsy_t == 1'b0) begin
        if (int'(vc_t) < vmin) vmin = int'(vc_t);
        if (int'(vc_t) > vmax) vmax = int'(vc_t);
      end
      if (fs_t) begin
        chk("tall_frame_period", cyc - last, 4200);
        last = cyc;
        nfs++;
      end
    end
    chk("tall_vsync_first", vmin, 490);
    chk("tall_vsync_last", vmax, 491);
    chk("tall_frame_count", nfs, 1);
    pix_t = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
